// File: rtl/destination_value_arbiter.sv
// rtl/destination_value_arbiter.sv - writeback arbiter: N result channels into one registered register-file write port
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module destination_value_arbiter #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 5,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*WORD_SIZE-1:0] ch_value,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
    output logic [NUM_CH-1:0]           ch_ready,
    input  logic                        prio_mode,
    output logic                        out_valid,
    output logic [WORD_SIZE-1:0]        out_value,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [CH_W-1:0]             out_ch,
    input  logic                        out_ready
);

    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] out_value_q, out_value_d;
    logic [ADDR_W-1:0]    out_addr_q,  out_addr_d;
    logic [CH_W-1:0]      out_ch_q,    out_ch_d;
    logic [CH_W-1:0]      rr_ptr_q,    rr_ptr_d;

    logic            grant_found;
    logic [CH_W-1:0] grant_idx;
    int              grant_sel;
    int              scan_j;
    logic            slot_free;
    logic            ch_xfer;

    // Grant search: fixed priority scans from 0, round-robin from rr_ptr with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_sel   = 0;
        scan_j      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (prio_mode) begin
                scan_j = k;
            end else begin
                scan_j = int'(rr_ptr_q) + k;
                if (scan_j >= NUM_CH) begin
                    scan_j = scan_j - NUM_CH;
                end
            end
            if (!grant_found && ch_valid[scan_j]) begin
                grant_found = 1'b1;
                grant_sel   = scan_j;
                grant_idx   = CH_W'(scan_j);
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    // reset_n masks the grant so nothing is accepted while reset is held.
    assign ch_xfer   = grant_found && slot_free && reset_n;
    assign ch_ready  = ch_xfer ? (NUM_CH'(1) << grant_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_addr_d  = out_addr_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (ch_xfer) begin
            out_valid_d = 1'b1;
            out_value_d = ch_value[grant_sel*WORD_SIZE +: WORD_SIZE];
            out_addr_d  = ch_addr[grant_sel*ADDR_W +: ADDR_W];
            out_ch_d    = grant_idx;
            rr_ptr_d    = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_addr_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_addr_q  <= out_addr_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_addr  = out_addr_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_destination_value_arbiter.sv
// tb/tb_destination_value_arbiter.sv - scoreboard bench for destination_value_arbiter (3-channel and 5-channel builds)
module tb_destination_value_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default build, 3 channels of 32-bit results
    logic [2:0]  a_ch_valid = '0;
    logic [31:0] a_val [3];
    logic [4:0]  a_adr [3];
    logic [95:0] a_ch_value;
    logic [14:0] a_ch_addr;
    logic [2:0]  a_ch_ready;
    logic        a_prio = 1'b0;
    logic        a_out_valid;
    logic [31:0] a_out_value;
    logic [4:0]  a_out_addr;
    logic [1:0]  a_out_ch;
    logic        a_out_ready = 1'b0;

    assign a_ch_value = {a_val[2], a_val[1], a_val[0]};
    assign a_ch_addr  = {a_adr[2], a_adr[1], a_adr[0]};

    destination_value_arbiter #(.WORD_SIZE(32), .NUM_CH(3), .ADDR_W(5)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .ch_valid(a_ch_valid), .ch_value(a_ch_value), .ch_addr(a_ch_addr),
        .ch_ready(a_ch_ready), .prio_mode(a_prio),
        .out_valid(a_out_valid), .out_value(a_out_value), .out_addr(a_out_addr),
        .out_ch(a_out_ch), .out_ready(a_out_ready)
    );

    // Instance B: 5 channels of 16-bit results
    logic [4:0]  b_ch_valid = '0;
    logic [15:0] b_val [5];
    logic [4:0]  b_adr [5];
    logic [79:0] b_ch_value;
    logic [24:0] b_ch_addr;
    logic [4:0]  b_ch_ready;
    logic        b_prio = 1'b0;
    logic        b_out_valid;
    logic [15:0] b_out_value;
    logic [4:0]  b_out_addr;
    logic [2:0]  b_out_ch;
    logic        b_out_ready = 1'b0;

    assign b_ch_value = {b_val[4], b_val[3], b_val[2], b_val[1], b_val[0]};
    assign b_ch_addr  = {b_adr[4], b_adr[3], b_adr[2], b_adr[1], b_adr[0]};

    destination_value_arbiter #(.WORD_SIZE(16), .NUM_CH(5), .ADDR_W(5)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .ch_valid(b_ch_valid), .ch_value(b_ch_value), .ch_addr(b_ch_addr),
        .ch_ready(b_ch_ready), .prio_mode(b_prio),
        .out_valid(b_out_valid), .out_value(b_out_value), .out_addr(b_out_addr),
        .out_ch(b_out_ch), .out_ready(b_out_ready)
    );

    // Scoreboard entries: {value[31:0], addr[7:0], ch[7:0]}
    logic [47:0] sb_a [$];
    logic [47:0] sb_b [$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && a_out_valid && a_out_ready) begin
            if (sb_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_output actual=%h expected=none", a_out_value);
            end else begin
                chk("a_out", {a_out_value, 3'b0, a_out_addr, 6'b0, a_out_ch}, sb_a.pop_front());
            end
        end
        if (reset_n && b_out_valid && b_out_ready) begin
            if (sb_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_output actual=%h expected=none", b_out_value);
            end else begin
                chk("b_out", {16'b0, b_out_value, 3'b0, b_out_addr, 5'b0, b_out_ch}, sb_b.pop_front());
            end
        end
    end

    function automatic int onehot_idx(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic step_a(input logic [2:0] v, input logic p, input logic ordy, input logic [2:0] exp_rdy);
        int g;
        @(posedge clk); #1;
        a_ch_valid  = v;
        a_prio      = p;
        a_out_ready = ordy;
        @(negedge clk);
        chk("a_ch_ready", {45'b0, a_ch_ready}, {45'b0, exp_rdy});
        if (exp_rdy != 3'b000) begin
            g = onehot_idx({2'b00, exp_rdy});
            sb_a.push_back({a_val[g], 3'b0, a_adr[g], 8'(g)});
        end
    endtask

    task automatic step_b(input logic [4:0] v, input logic ordy, input logic [4:0] exp_rdy);
        int g;
        @(posedge clk); #1;
        b_ch_valid  = v;
        b_out_ready = ordy;
        @(negedge clk);
        chk("b_ch_ready", {43'b0, b_ch_ready}, {43'b0, exp_rdy});
        if (exp_rdy != 5'b00000) begin
            g = onehot_idx(exp_rdy);
            sb_b.push_back({16'b0, b_val[g], 3'b0, b_adr[g], 8'(g)});
        end
    endtask

    initial begin
        a_val[0] = 32'h0000_0005; a_adr[0] = 5'd3;
        a_val[1] = 32'h2222_0001; a_adr[1] = 5'd17;
        a_val[2] = 32'h3333_0002; a_adr[2] = 5'd30;
        for (int i = 0; i < 5; i++) begin
            b_val[i] = 16'hA0A0 + 16'(i * 16'h0101);
            b_adr[i] = 5'(10 + i);
        end

        // Reset: everything zero and the grant masked even with ch0 valid
        a_ch_valid = 3'b001;
        @(negedge clk);
        chk("rst_out_valid", {47'b0, a_out_valid}, 48'd0);
        chk("rst_out_value", {16'b0, a_out_value}, 48'd0);
        chk("rst_out_addr",  {43'b0, a_out_addr}, 48'd0);
        chk("rst_out_ch",    {46'b0, a_out_ch}, 48'd0);
        chk("rst_ch_ready",  {45'b0, a_ch_ready}, 48'd0);
        @(posedge clk); #1;
        a_ch_valid = 3'b000;
        reset_n    = 1'b1;

        // Single add result, visible one cycle later
        step_a(3'b001, 1'b0, 1'b1, 3'b001);
        step_a(3'b000, 1'b0, 1'b1, 3'b000);
        chk("lat_out_valid", {47'b0, a_out_valid}, 48'd1);
        chk("lat_out_value", {16'b0, a_out_value}, 48'd5);
        chk("lat_out_addr",  {43'b0, a_out_addr}, 48'd3);

        // rr_ptr is 1 now; a ch2 grant brings it back to 0
        step_a(3'b100, 1'b0, 1'b1, 3'b100);

        // Round-robin, all channels valid
        step_a(3'b111, 1'b0, 1'b1, 3'b001);
        step_a(3'b111, 1'b0, 1'b1, 3'b010);
        step_a(3'b111, 1'b0, 1'b1, 3'b100);
        step_a(3'b111, 1'b0, 1'b1, 3'b001);
        step_a(3'b111, 1'b0, 1'b1, 3'b010);
        step_a(3'b111, 1'b0, 1'b1, 3'b100);

        // Fixed priority starves channels 1 and 2
        for (int i = 0; i < 6; i++) step_a(3'b111, 1'b1, 1'b1, 3'b001);
        step_a(3'b000, 1'b0, 1'b1, 3'b000);

        // Backpressure: load ch0 (rr -> 1), then stall with ch1/ch2 waiting
        step_a(3'b001, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 4; i++) begin
            step_a(3'b110, 1'b0, 1'b0, 3'b000);
            chk("bp_out_valid", {47'b0, a_out_valid}, 48'd1);
            chk("bp_out_value", {16'b0, a_out_value}, {16'b0, a_val[0]});
            chk("bp_out_ch",    {46'b0, a_out_ch}, 48'd0);
        end
        step_a(3'b110, 1'b0, 1'b1, 3'b010);

        // No bubble: ch1 loaded on the drain edge; then asynchronous reset discards it
        @(posedge clk); #1;
        a_ch_valid  = 3'b100;
        a_out_ready = 1'b0;
        chk("nobubble_valid", {47'b0, a_out_valid}, 48'd1);
        chk("nobubble_ch",    {46'b0, a_out_ch}, 48'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {47'b0, a_out_valid}, 48'd0);
        chk("async_rst_value", {16'b0, a_out_value}, 48'd0);
        chk("async_rst_ready", {45'b0, a_ch_ready}, 48'd0);
        sb_a.delete();
        @(posedge clk); #1;
        chk("rst_edge_no_accept", {47'b0, a_out_valid}, 48'd0);
        reset_n     = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {45'b0, a_ch_ready}, 48'h4);
        sb_a.push_back({a_val[2], 3'b0, a_adr[2], 8'd2});
        step_a(3'b000, 1'b0, 1'b1, 3'b000);
        chk("post_rst_ch2_loaded", {46'b0, a_out_ch}, 48'd2);
        step_a(3'b111, 1'b0, 1'b1, 3'b001);
        step_a(3'b000, 1'b0, 1'b1, 3'b000);

        // 5-channel build: grant ch4, rr wraps to 0, then ch0 beats ch1
        step_b(5'b10000, 1'b1, 5'b10000);
        step_b(5'b00011, 1'b1, 5'b00001);
        step_b(5'b00011, 1'b1, 5'b00010);
        step_b(5'b00000, 1'b1, 5'b00000);

        repeat (2) @(posedge clk);
        chk("sb_a_empty", 48'(sb_a.size()), 48'd0);
        chk("sb_b_empty", 48'(sb_b.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
